color_sequencer: RTL

//  Photodiode-filter sequencer between freq_counter (upstream) and calc_perc (downstream).

---
 rtl/color_sequencer_pkg.sv | 50 +++++
 rtl/color_sequencer_sweep_timer.sv | 38 +++
 rtl/color_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/color_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// color_sequencer_pkg
// Shared definitions for the colour-sensor filter sequencer:
//   - CS codes driven onto the sensor S2/S3 pins for each photodiode filter
//   - filter index (sweep order CLEAR, RED, GREEN, BLUE)
//   - sequencer state encoding
//   - one-hot dominant-colour codes
// -----------------------------------------------------------------------------
package color_sequencer_pkg;

    // S2/S3 codes for each photodiode filter
    localparam logic [1:0] CS_RED   = 2'b00;
    localparam logic [1:0] CS_GREEN = 2'b11;
    localparam logic [1:0] CS_BLUE  = 2'b01;
    localparam logic [1:0] CS_CLEAR = 2'b10;

    // Filter index; the numeric order is the sweep order
    typedef enum logic [1:0] {
        IDX_CLEAR = 2'd0,
        IDX_RED   = 2'd1,
        IDX_GREEN = 2'd2,
        IDX_BLUE  = 2'd3
    } filter_idx_e;

    typedef enum logic [2:0] {
        ST_SELECT     = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_DISCARD    = 3'd2,
        ST_CAPTURE    = 3'd3,
        ST_NORM_START = 3'd4,
        ST_NORM_RUN   = 3'd5,
        ST_DECIDE     = 3'd6
    } state_e;

    // One-hot dominant colour
    localparam logic [2:0] COLOR_NONE  = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b100;

    function automatic logic [1:0] cs_code(input filter_idx_e idx);
        case (idx)
            IDX_RED:   return CS_RED;
            IDX_GREEN: return CS_GREEN;
            IDX_BLUE:  return CS_BLUE;
            default:   return CS_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/color_sequencer_sweep_timer.sv
// -----------------------------------------------------------------------------
// color_sequencer_sweep_timer
// Loadable down-counter shared by the settle wait and the period timeout.
// The counter stops at zero; o_tc is high whenever it sits at zero.
// Ports:
//   i_clk       system clock
//   i_reset     asynchronous, active-high
//   i_load      load i_load_val this cycle (takes priority over counting)
//   i_load_val  value to load (number of remaining cycles minus one)
//   o_tc        terminal count: counter is zero
// -----------------------------------------------------------------------------
module color_sequencer_sweep_timer #(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/color_sequencer.sv
// -----------------------------------------------------------------------------
// color_sequencer
// Steps the colour sensor through CLEAR, RED, GREEN, BLUE filters, captures one
// settled period per filter, has calc_perc normalise each colour against the
// clear period, and publishes the dominant colour as a one-hot code.
// Ports:
//   i_clk             system clock
//   i_reset           asynchronous, active-high
//   i_period          period from freq_counter
//   i_period_valid    1-cycle strobe: new period on i_period
//   i_calc_done       calc_perc result ready (level)
//   i_percent         calc_perc result (colour/clear*100)
//   o_cs              sensor S2/S3 filter select
//   o_calc_en         calc_perc enable
//   o_calc_reset      calc_perc reset, one-cycle pulse per colour
//   o_color_raw       calc_perc numerator (colour period)
//   o_clear           calc_perc denominator (clear period)
//   o_color_detected  one-hot dominant colour: [0] red [1] green [2] blue
// -----------------------------------------------------------------------------
module color_sequencer
    import color_sequencer_pkg::*;
#(
    parameter int         PW          = 19,
    parameter int         SETTLE_CYC  = 100000,
    parameter int         TIMEOUT_CYC = 2000000,
    parameter logic [7:0] PCT_THRESH  = 8'd60
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [PW-1:0] i_period,
    input  logic          i_period_valid,
    input  logic          i_calc_done,
    input  logic [7:0]    i_percent,
    output logic [1:0]    o_cs,
    output logic          o_calc_en,
    output logic          o_calc_reset,
    output logic [PW-1:0] o_color_raw,
    output logic [PW-1:0] o_clear,
    output logic [2:0]    o_color_detected
);

    localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TW      = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    state_e        r_state;
    state_e        w_next_state;
    filter_idx_e   r_filter;      // filter being captured
    filter_idx_e   r_colour;      // colour being normalised
    logic [PW-1:0] r_cap [4];     // captured periods, indexed by filter
    logic [7:0]    r_pct [4];     // normalised percents, colour entries only
    logic [1:0]    r_cs;
    logic          r_calc_en;
    logic          r_calc_reset;
    logic [PW-1:0] r_color_raw;
    logic [PW-1:0] r_clear;
    logic [2:0]    r_color_detected;

    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_tc;
    logic          w_timeout;
    logic          w_capture;
    logic          w_pct_latch;
    logic          w_decide;
    logic [7:0]    w_min_pct;
    logic [2:0]    w_win;
    logic [2:0]    w_decision;

    color_sequencer_sweep_timer #(.CW(TW)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    // Next-state and control decode
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = TW'(SETTLE_CYC - 1);
        w_timeout    = 1'b0;
        w_capture    = 1'b0;
        w_pct_latch  = 1'b0;
        w_decide     = 1'b0;

        case (r_state)
            ST_SELECT: begin
                w_tmr_load   = 1'b1;
                w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Strobes here span the filter switch and are ignored
                if (w_tmr_tc) begin
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = TW'(TIMEOUT_CYC - 1);
                    w_next_state = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // A strobe beats a simultaneous terminal count
                if (i_period_valid) begin
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = TW'(TIMEOUT_CYC - 1);
                    w_next_state = ST_CAPTURE;
                end else if (w_tmr_tc) begin
                    w_timeout = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (i_period_valid) begin
                    // A zero clear period would divide by zero downstream
                    if (r_filter == IDX_CLEAR && i_period == '0) begin
                        w_timeout = 1'b1;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = (r_filter == IDX_BLUE) ? ST_NORM_START : ST_SELECT;
                    end
                end else if (w_tmr_tc) begin
                    w_timeout = 1'b1;
                end
            end
            ST_NORM_START: begin
                w_next_state = ST_NORM_RUN;
            end
            ST_NORM_RUN: begin
                if (i_calc_done) begin
                    w_pct_latch  = 1'b1;
                    w_next_state = (r_colour == IDX_BLUE) ? ST_DECIDE : ST_NORM_START;
                end
            end
            ST_DECIDE: begin
                w_decide     = 1'b1;
                w_next_state = ST_SELECT;
            end
            default: begin
                w_next_state = ST_SELECT;
            end
        endcase

        if (w_timeout) begin
            w_next_state = ST_SELECT;
        end
    end

    // Shortest normalised period wins; strict compares give red > green > blue on ties
    always_comb begin
        w_win     = COLOR_RED;
        w_min_pct = r_pct[IDX_RED];
        if (r_pct[IDX_GREEN] < w_min_pct) begin
            w_win     = COLOR_GREEN;
            w_min_pct = r_pct[IDX_GREEN];
        end
        if (r_pct[IDX_BLUE] < w_min_pct) begin
            w_win     = COLOR_BLUE;
            w_min_pct = r_pct[IDX_BLUE];
        end
        w_decision = (w_min_pct >= PCT_THRESH) ? COLOR_NONE : w_win;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= ST_SELECT;
            r_filter         <= IDX_CLEAR;
            r_colour         <= IDX_RED;
            r_cs             <= CS_CLEAR;
            r_calc_en        <= 1'b0;
            r_calc_reset     <= 1'b1;
            r_color_raw      <= '0;
            r_clear          <= '0;
            r_color_detected <= COLOR_NONE;
            // NOTE: these small register arrays are reset explicitly because
            // stale periods/percents must never leak into a later decision;
            // large RAM-style arrays would normally be left unreset.
            for (int i = 0; i < 4; i++) begin
                r_cap[i] <= '0;
                r_pct[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;

            // Registered strobes line up exactly with the NORM_START / NORM_RUN cycles
            r_calc_reset <= (w_next_state == ST_NORM_START);
            r_calc_en    <= (w_next_state == ST_NORM_RUN);

            if (r_state == ST_SELECT) begin
                r_cs <= cs_code(r_filter);
            end

            if (w_capture) begin
                r_cap[r_filter] <= i_period;
                if (r_filter == IDX_BLUE) begin
                    r_colour <= IDX_RED;
                end else begin
                    r_filter <= filter_idx_e'(r_filter + 2'd1);
                end
            end

            if (w_timeout) begin
                r_color_detected <= COLOR_NONE;
                r_filter         <= IDX_CLEAR;
            end

            // Operands are loaded before calc_EN rises and held until the next colour
            if (r_state == ST_NORM_START) begin
                r_color_raw <= r_cap[r_colour];
                r_clear     <= r_cap[IDX_CLEAR];
            end

            if (w_pct_latch) begin
                r_pct[r_colour] <= i_percent;
                if (r_colour != IDX_BLUE) begin
                    r_colour <= filter_idx_e'(r_colour + 2'd1);
                end
            end

            if (w_decide) begin
                r_color_detected <= w_decision;
                r_filter         <= IDX_CLEAR;
            end
        end
    end

    assign o_cs             = r_cs;
    assign o_calc_en        = r_calc_en;
    assign o_calc_reset     = r_calc_reset;
    assign o_color_raw      = r_color_raw;
    assign o_clear          = r_clear;
    assign o_color_detected = r_color_detected;

endmodule
